port_arbiter: RTL and testbench

Two-requester command arbiter and sequencer in front of the GPIO `port` block, which holds the DDR/PORT registers and pin mux for ports A, B and C.

- Both requesters (the CPU core and a secondary master, e.g. a debug or blink engine) issue word writes, pin reads and single-bit set/clear/toggle commands.
- Access is granted round-robin, and each command runs as one strobe cycle on the `port` interface.
- A shadow copy of the three PORT registers makes bit operations true read-modify-write without reading back the pins.

---
 rtl/port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Two-requester round-robin command sequencer in front of the GPIO port block.
// Each accepted command runs IDLE -> EXEC (single strobe) -> RESP (single response pulse).
module port_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [1:0]        req0_port,
   input  logic [2:0]        req0_bit,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [1:0]        req1_port,
   input  logic [2:0]        req1_bit,
   input  logic [DATA_W-1:0] req1_data,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] p_dane,
   output logic [1:0]        p_nr_ddr,
   output logic [1:0]        p_nr_port,
   output logic [1:0]        p_nr_pin,
   output logic              p_wr_ddr,
   output logic              p_wr_port,
   input  logic [DATA_W-1:0] p_pin,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [2:0] OP_WR_DDR  = 3'd0;
   localparam logic [2:0] OP_WR_PORT = 3'd1;
   localparam logic [2:0] OP_RD_PIN  = 3'd2;
   localparam logic [2:0] OP_SET_BIT = 3'd3;
   localparam logic [2:0] OP_CLR_BIT = 3'd4;
   localparam logic [2:0] OP_TGL_BIT = 3'd5;
   localparam logic [2:0] OP_RD_PORT = 3'd6;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;       // 1 = req1 wins a tie
   logic              owner_q, owner_d;
   logic [2:0]        op_q, op_d;
   logic [1:0]        port_q, port_d;
   logic [2:0]        bit_q, bit_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] shadow_q [3];

   logic              grant0, grant1, illegal, shadow_we;
   logic [DATA_W-1:0] cur_shadow, bit_mask, new_val;

   assign grant0  = req0_valid && (!req1_valid || !ptr_q);
   assign grant1  = req1_valid && !grant0;
   assign illegal = (port_q == 2'd3) || (op_q == 3'd7);
   assign bit_mask = DATA_W'(1) << bit_q;

   always_comb begin
      cur_shadow = '0;
      for (int i = 0; i < 3; i++) begin
         if (port_q == 2'(i)) cur_shadow = shadow_q[i];
      end
   end

   // Value driven to the PORT register for word writes and read-modify-write bit ops.
   always_comb begin
      case (op_q)
         OP_SET_BIT: new_val = cur_shadow | bit_mask;
         OP_CLR_BIT: new_val = cur_shadow & ~bit_mask;
         OP_TGL_BIT: new_val = cur_shadow ^ bit_mask;
         default:    new_val = data_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      op_d       = op_q;
      port_d     = port_q;
      bit_d      = bit_q;
      data_d     = data_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      p_dane     = '0;
      p_nr_ddr   = '0;
      p_nr_port  = '0;
      p_nr_pin   = '0;
      p_wr_ddr   = 1'b0;
      p_wr_port  = 1'b0;
      shadow_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant0 || grant1) begin
               req0_ready = grant0;
               req1_ready = grant1;
               owner_d    = grant1;
               ptr_d      = grant0;
               op_d       = grant1 ? req1_op   : req0_op;
               port_d     = grant1 ? req1_port : req0_port;
               bit_d      = grant1 ? req1_bit  : req0_bit;
               data_d     = grant1 ? req1_data : req0_data;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d    = S_RESP;
            rsp_err_d  = illegal;
            rsp_data_d = '0;
            if (!illegal) begin
               case (op_q)
                  OP_WR_DDR: begin
                     p_nr_ddr   = port_q;
                     p_dane     = data_q;
                     p_wr_ddr   = 1'b1;
                     rsp_data_d = data_q;
                  end
                  OP_WR_PORT, OP_SET_BIT, OP_CLR_BIT, OP_TGL_BIT: begin
                     p_nr_port  = port_q;
                     p_dane     = new_val;
                     p_wr_port  = 1'b1;
                     shadow_we  = 1'b1;
                     rsp_data_d = new_val;
                  end
                  OP_RD_PIN: begin
                     p_nr_pin   = port_q;
                     rsp_data_d = p_pin;
                  end
                  OP_RD_PORT: rsp_data_d = cur_shadow;
                  default: ;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A reset landing mid-command must not leave a stray write or grant behind.
      if (rst) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         p_wr_ddr   = 1'b0;
         p_wr_port  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= 1'b0;
         owner_q    <= 1'b0;
         op_q       <= '0;
         port_q     <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         op_q       <= op_d;
         port_q     <= port_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         for (int i = 0; i < 3; i++) begin
            if (shadow_we && port_q == 2'(i)) shadow_q[i] <= new_val;
         end
      end
   end

   assign rsp0_valid = (state_q == S_RESP) && !owner_q && !rst;
   assign rsp1_valid = (state_q == S_RESP) &&  owner_q && !rst;
   assign rsp0_data  = rsp0_valid ? rsp_data_q : '0;
   assign rsp1_data  = rsp1_valid ? rsp_data_q : '0;
   assign rsp0_err   = rsp0_valid && rsp_err_q;
   assign rsp1_err   = rsp1_valid && rsp_err_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_port_arbiter.sv
// Scoreboard bench for port_arbiter: two drivers, a port-block model, and a
// negedge monitor comparing strobes, responses and grants against a command-level model.
module tb_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_op, req1_op, req0_bit, req1_bit;
   logic [1:0] req0_port, req1_port;
   logic [7:0] req0_data, req1_data;
   logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [7:0] rsp0_data, rsp1_data;
   logic [7:0] p_dane, p_pin;
   logic [1:0] p_nr_ddr, p_nr_port, p_nr_pin;
   logic       p_wr_ddr, p_wr_port, busy;

   always #5 clk = ~clk;

   port_arbiter #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_port(req0_port), .req0_bit(req0_bit), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_port(req1_port), .req1_bit(req1_bit), .req1_data(req1_data),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .p_dane(p_dane), .p_nr_ddr(p_nr_ddr), .p_nr_port(p_nr_port), .p_nr_pin(p_nr_pin),
      .p_wr_ddr(p_wr_ddr), .p_wr_port(p_wr_port), .p_pin(p_pin), .busy(busy)
   );

   typedef struct {logic [2:0] op; logic [1:0] port; logic [2:0] bitn; logic [7:0] data;} cmd_t;
   typedef struct {int cyc; logic [7:0] data; logic err;} rsp_t;
   typedef struct {int cyc; logic wr_ddr; logic wr_port; logic [7:0] dane;
                   logic [1:0] nr_ddr; logic [1:0] nr_port; logic [1:0] nr_pin;} stb_t;

   cmd_t cmd_q0[$], cmd_q1[$];
   rsp_t rsp_q0[$], rsp_q1[$];
   stb_t stb_q[$];
   logic grant_log[$];

   int   n_chk = 0, n_pass = 0, cyc = 0, grants = 0, stb_cnt = 0, rsp_seen0 = 0;
   logic [7:0] m_ddr [4], m_port [4], pad [4];
   logic       m_ptr = 1'b0;
   int         m_grant_cyc = -100;
   logic       gap_en = 1'b1, drv_act0 = 1'b0, drv_act1 = 1'b0;
   logic [7:0] last_rsp0_data = '0, last_dane = '0;
   logic       last_rsp0_err = 1'b0;
   logic [1:0] last_nr_port = '0;

   // Model of the external port block: DDR/PORT registers and pin mux.
   logic [7:0] env_ddr [4], env_port [4];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            env_ddr[i]  <= '0;
            env_port[i] <= '0;
         end
      end else begin
         if (p_wr_ddr)  env_ddr[p_nr_ddr]   <= p_dane;
         if (p_wr_port) env_port[p_nr_port] <= p_dane;
      end
   end
   always_comb p_pin = (env_ddr[p_nr_pin] & env_port[p_nr_pin]) | (~env_ddr[p_nr_pin] & pad[p_nr_pin]);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic cmd_t mk(input logic [2:0] op, input logic [1:0] pt, input logic [2:0] b, input logic [7:0] d);
      cmd_t c;
      c.op = op; c.port = pt; c.bitn = b; c.data = d;
      return c;
   endfunction

   function automatic cmd_t rnd_cmd();
      return mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom), 8'($urandom));
   endfunction

   // Command-level reference: apply the granted command to the modelled registers.
   task automatic model_grant(input logic win);
      logic [2:0] op; logic [1:0] pt; logic [2:0] b; logic [7:0] d, v, m;
      rsp_t r; stb_t s;
      op = win ? req1_op : req0_op;
      pt = win ? req1_port : req0_port;
      b  = win ? req1_bit : req0_bit;
      d  = win ? req1_data : req0_data;
      m  = 8'd1 << b;
      r.cyc = cyc + 2; r.data = '0; r.err = 1'b0;
      s.cyc = cyc + 1; s.wr_ddr = 0; s.wr_port = 0; s.dane = '0;
      s.nr_ddr = '0; s.nr_port = '0; s.nr_pin = '0;
      if (pt == 2'd3 || op == 3'd7) r.err = 1'b1;
      else begin
         case (op)
            3'd0: begin m_ddr[pt] = d; r.data = d; s.wr_ddr = 1; s.dane = d; s.nr_ddr = pt; end
            3'd1, 3'd3, 3'd4, 3'd5: begin
               if (op == 3'd1)      v = d;
               else if (op == 3'd3) v = m_port[pt] | m;
               else if (op == 3'd4) v = m_port[pt] & ~m;
               else                 v = m_port[pt] ^ m;
               m_port[pt] = v; r.data = v; s.wr_port = 1; s.dane = v; s.nr_port = pt;
            end
            3'd2: begin r.data = (m_ddr[pt] & m_port[pt]) | (~m_ddr[pt] & pad[pt]); s.nr_pin = pt; end
            default: r.data = m_port[pt];
         endcase
      end
      if (win) rsp_q1.push_back(r); else rsp_q0.push_back(r);
      stb_q.push_back(s);
      m_ptr = !win;
      m_grant_cyc = cyc;
      grants++;
      grant_log.push_back(win);
   endtask

   always @(negedge clk) begin : mon
      stb_t s; rsp_t r; logic m_idle, win;
      cyc = cyc + 1;
      if (rst) begin
         chk("rst_wr_ddr", 32'(p_wr_ddr), 0);
         chk("rst_wr_port", 32'(p_wr_port), 0);
         chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
         chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
         chk("rst_ready", 32'({req0_ready, req1_ready}), 0);
         stb_q.delete(); rsp_q0.delete(); rsp_q1.delete();
         for (int i = 0; i < 4; i++) begin m_ddr[i] = '0; m_port[i] = '0; end
         m_ptr = 1'b0;
         m_grant_cyc = -100;
      end else begin
         m_idle = (cyc > m_grant_cyc + 2);
         chk("busy", 32'(busy), 32'(!m_idle));
         s.cyc = 0; s.wr_ddr = 0; s.wr_port = 0; s.dane = '0; s.nr_ddr = '0; s.nr_port = '0; s.nr_pin = '0;
         if (stb_q.size() != 0 && stb_q[0].cyc == cyc) s = stb_q.pop_front();
         chk("p_wr_ddr", 32'(p_wr_ddr), 32'(s.wr_ddr));
         chk("p_wr_port", 32'(p_wr_port), 32'(s.wr_port));
         chk("p_dane", 32'(p_dane), 32'(s.dane));
         chk("p_nr_ddr", 32'(p_nr_ddr), 32'(s.nr_ddr));
         chk("p_nr_port", 32'(p_nr_port), 32'(s.nr_port));
         chk("p_nr_pin", 32'(p_nr_pin), 32'(s.nr_pin));
         if (p_wr_ddr || p_wr_port) begin stb_cnt++; last_dane = p_dane; last_nr_port = p_nr_port; end
         if (rsp_q0.size() != 0 && rsp_q0[0].cyc == cyc) begin
            r = rsp_q0.pop_front();
            chk("rsp0_valid", 32'(rsp0_valid), 1);
            chk("rsp0_data", 32'(rsp0_data), 32'(r.data));
            chk("rsp0_err", 32'(rsp0_err), 32'(r.err));
         end else chk("rsp0_valid_quiet", 32'(rsp0_valid), 0);
         if (rsp_q1.size() != 0 && rsp_q1[0].cyc == cyc) begin
            r = rsp_q1.pop_front();
            chk("rsp1_valid", 32'(rsp1_valid), 1);
            chk("rsp1_data", 32'(rsp1_data), 32'(r.data));
            chk("rsp1_err", 32'(rsp1_err), 32'(r.err));
         end else chk("rsp1_valid_quiet", 32'(rsp1_valid), 0);
         if (rsp0_valid) begin rsp_seen0++; last_rsp0_data = rsp0_data; last_rsp0_err = rsp0_err; end
         if (m_idle && (req0_valid || req1_valid)) begin
            win = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
            chk("req0_ready", 32'(req0_ready), 32'(!win));
            chk("req1_ready", 32'(req1_ready), 32'(win));
            model_grant(win);
         end else begin
            chk("req0_ready_quiet", 32'(req0_ready), 0);
            chk("req1_ready_quiet", 32'(req1_ready), 0);
         end
      end
   end

   initial begin : drv0
      cmd_t c; int n;
      req0_valid = 0; req0_op = '0; req0_port = '0; req0_bit = '0; req0_data = '0;
      forever begin
         if (cmd_q0.size() == 0 || rst) begin
            drv_act0 = 1'b0;
            @(posedge clk); #1;
         end else begin
            drv_act0 = 1'b1;
            c = cmd_q0.pop_front();
            req0_op = c.op; req0_port = c.port; req0_bit = c.bitn; req0_data = c.data;
            req0_valid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!req0_ready && n < 100);
            if (!req0_ready) chk("drv0_grant_timeout", 0, 1);
            @(posedge clk); #1;
            req0_valid = 1'b0;
            req0_op = 3'($urandom); req0_port = 2'($urandom); req0_bit = 3'($urandom); req0_data = 8'($urandom);
            if (gap_en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
      end
   end

   initial begin : drv1
      cmd_t c; int n;
      req1_valid = 0; req1_op = '0; req1_port = '0; req1_bit = '0; req1_data = '0;
      forever begin
         if (cmd_q1.size() == 0 || rst) begin
            drv_act1 = 1'b0;
            @(posedge clk); #1;
         end else begin
            drv_act1 = 1'b1;
            c = cmd_q1.pop_front();
            req1_op = c.op; req1_port = c.port; req1_bit = c.bitn; req1_data = c.data;
            req1_valid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!req1_ready && n < 100);
            if (!req1_ready) chk("drv1_grant_timeout", 0, 1);
            @(posedge clk); #1;
            req1_valid = 1'b0;
            req1_op = 3'($urandom); req1_port = 2'($urandom); req1_bit = 3'($urandom); req1_data = 8'($urandom);
            if (gap_en) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
      end
   end

   task automatic drain();
      int n; logic done;
      n = 0;
      done = 1'b0;
      while (!done && n < 3000) begin
         @(posedge clk); #1; n++;
         done = cmd_q0.size() == 0 && cmd_q1.size() == 0 && !drv_act0 && !drv_act1 &&
                rsp_q0.size() == 0 && rsp_q1.size() == 0 && stb_q.size() == 0 &&
                (cyc > m_grant_cyc + 2);
      end
      chk("drain_timeout", 32'(done), 1);
   endtask

   task automatic run0(input logic [2:0] op, input logic [1:0] pt, input logic [2:0] b, input logic [7:0] d);
      cmd_q0.push_back(mk(op, pt, b, d));
      drain();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin : main
      int g, n, sc, rs;
      logic [7:0] pads [4];
      rst = 1'b1;
      for (int i = 0; i < 4; i++) pad[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_strobes", 32'({p_wr_ddr, p_wr_port}), 0);
      chk("reset_rsp_data", 32'(rsp0_data), 0);
      @(posedge clk); #1;

      run0(3'd6, 2'd2, 3'd0, 8'h00);
      chk("reset_rdport_C", 32'(last_rsp0_data), 32'h00);
      chk("reset_rdport_C_err", 32'(last_rsp0_err), 0);

      run0(3'd1, 2'd2, 3'd0, 8'hA5);
      chk("wrport_C_dane", 32'(last_dane), 32'hA5);
      chk("wrport_C_nr", 32'(last_nr_port), 2);
      run0(3'd3, 2'd2, 3'd1, 8'h00);
      chk("setbit_C1_dane", 32'(last_dane), 32'hA7);
      run0(3'd5, 2'd2, 3'd7, 8'h00);
      chk("tglbit_C7_dane", 32'(last_dane), 32'h27);
      run0(3'd4, 2'd2, 3'd0, 8'h00);
      chk("clrbit_C0_dane", 32'(last_dane), 32'h26);
      run0(3'd6, 2'd2, 3'd0, 8'h00);
      chk("rdport_C", 32'(last_rsp0_data), 32'h26);

      pad[0] = 8'hBC;
      run0(3'd0, 2'd0, 3'd0, 8'h0F);
      run0(3'd1, 2'd0, 3'd0, 8'h03);
      run0(3'd2, 2'd0, 3'd0, 8'h00);
      chk("rdpin_A", 32'(last_rsp0_data), 32'hB3);

      sc = stb_cnt;
      run0(3'd1, 2'd3, 3'd0, 8'h55);
      chk("illegal_port_err", 32'(last_rsp0_err), 1);
      chk("illegal_port_data", 32'(last_rsp0_data), 0);
      run0(3'd7, 2'd0, 3'd0, 8'h55);
      chk("illegal_op_err", 32'(last_rsp0_err), 1);
      chk("illegal_op_data", 32'(last_rsp0_data), 0);
      chk("illegal_no_strobe", 32'(stb_cnt), 32'(sc));
      run0(3'd6, 2'd0, 3'd0, 8'h00);
      chk("illegal_shadow_A", 32'(last_rsp0_data), 32'h03);

      // Reset asserted during the EXEC cycle of a DDR write.
      g = grants; sc = stb_cnt; rs = rsp_seen0;
      cmd_q0.push_back(mk(3'd0, 2'd1, 3'd0, 8'hFF));
      n = 0;
      while (grants == g && n < 100) begin @(posedge clk); #1; n++; end
      chk("midrst_grant", 32'(grants != g), 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_strobe", 32'(stb_cnt), 32'(sc));
      chk("midrst_no_rsp", 32'(rsp_seen0), 32'(rs));
      pad[1] = 8'h5A;
      run0(3'd2, 2'd1, 3'd0, 8'h00);
      chk("midrst_ddr_B_clear", 32'(last_rsp0_data), 32'h5A);
      run0(3'd6, 2'd2, 3'd0, 8'h00);
      chk("midrst_shadow_C", 32'(last_rsp0_data), 32'h00);

      // Both requesters continuously valid: grants must alternate starting with req0.
      do_reset();
      gap_en = 1'b0;
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         cmd_q0.push_back(rnd_cmd());
         cmd_q1.push_back(rnd_cmd());
      end
      drain();
      chk("arb_grant_count", 32'(grant_log.size()), 8);
      for (int i = 0; i < grant_log.size(); i++) chk("arb_alternate", 32'(grant_log[i]), 32'(i % 2));

      gap_en = 1'b1;
      for (int i = 0; i < 4; i++) pads[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) pad[i] = pads[i];
      for (int i = 0; i < 150; i++) begin
         cmd_q0.push_back(rnd_cmd());
         cmd_q1.push_back(rnd_cmd());
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
